dvp_byte_tx: RTL
================

Name: dvp_byte_tx

Overview:
- DVP-style camera-side transmitter (camera emulator / loopback source).
- Accepts 16-bit RGB565 pixels over a valid/ready handshake and serialises each one as two bytes, high byte first.
- Generates frame timing: vs_o pulse, back porch, per-line de_o windows with horizontal blanking, and front porch.
- Output stream is byte- and timing-compatible with the team's byte-joining receiver, so the receiver can be driven in bench and on-board loopback without a sensor.

Parameters:
H_ACTIVE, 640, pixels per line (line carries 2*H_ACTIVE bytes)
V_ACTIVE, 480, active lines per frame
H_BLANK, 16, de_o-low cycles after each active line (min 1)
VS_CYCLES, 8, cycles vs_o held high at frame start (min 1)
V_BACK, 32, cycles between vs_o fall and first active line (min 1)
V_FRONT, 32, cycles after last line's blanking before frame end (min 1)

Ports:
tpclk  in  1  byte clock, one output byte per cycle
rst_n  in  1  asynchronous active-low reset
enable  in  1  frame start permission, sampled only in IDLE
pix_data  in  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
pix_valid  in  1  pix_data valid
pix_ready  out  1  block takes pix_data this cycle if pix_valid
data_out  out  8  byte stream
de_o  out  1  high while data_out carries pixel bytes
vs_o  out  1  frame sync, active high
underflow  out  1  sticky: pixel missing during active line
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; data_out=0x00; de_o=0; vs_o=0; underflow=0; frame_done=0. Reset mid-frame aborts immediately; the next frame starts from VSYNC after release.
- data_out, de_o, vs_o, underflow and frame_done are registered. pix_ready is combinational from state and phase only; it never depends on pix_valid.
- States: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
- IDLE -> VSYNC when enable=1. vs_o=1 in the cycle after enable is sampled.
- VSYNC: vs_o=1 for exactly VS_CYCLES cycles, then VBACK.
- VBACK: V_BACK cycles with vs_o=0 and de_o=0, then ACTIVE with line=0 and byte phase=0.
- ACTIVE: 2*H_ACTIVE consecutive de_o=1 cycles, then HBLANK.
- HBLANK: H_BLANK cycles with de_o=0 and data_out=0x00.
  - If line==V_ACTIVE-1: go to VFRONT.
  - Otherwise: line+1, back to ACTIVE.
- VFRONT: V_FRONT cycles. On the last cycle frame_done=1 for one cycle. Then:
  - if enable=1, go straight to VSYNC (no idle gap);
  - otherwise go to IDLE.
- enable deassertion mid-frame has no effect; the current frame always completes.
- Pixel handshake:
  - pix_ready=1 only in the cycle before each even-phase active byte, i.e. the cycle whose next output is a high byte. This covers the last VBACK cycle, the last HBLANK cycle of a non-final line, and ACTIVE odd-phase cycles that are not the line's last byte.
  - Accepted pixel (pix_valid=1 and pix_ready=1): high byte appears on data_out next cycle, low byte the cycle after. The low byte is held internally.
  - pix_valid=0 at a pix_ready cycle: both bytes of that pixel go out as 0x00, de_o still 1, underflow set to 1.
  - underflow clears only when the next VSYNC begins, i.e. in the cycle vs_o rises.
- Byte order fixed: pix_data[15:8] then pix_data[7:0].
- Outside ACTIVE, data_out=0x00.
- Counter widths are $clog2 of the respective parameter, plus 1. No wraparound within a frame.
- Exactly H_ACTIVE*V_ACTIVE handshakes occur per frame.

Optional Feature:
DVP_TX_COLORBAR_EN
- Defined:
  - Adds input pattern_en (1 bit).
  - With pattern_en=1, pix_ready is held 0 and pixels come from an internal 8-bar colour pattern.
  - Bar index = pixel_x*8/H_ACTIVE. Colours are white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - underflow never sets while pattern_en=1.
  - pattern_en is sampled only at VSYNC entry and held for the frame.
- Not defined: no pattern_en port, no pattern logic; pixels come only from pix_data.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VS_CYCLES=2, V_BACK=2, V_FRONT=2):
- Idle after reset: enable=0 for 50 cycles -> all outputs 0, pix_ready=0.
- One frame, pixels 0x1234, 0x5678, ... always valid, enable pulsed one cycle:
  - vs_o high 2 cycles, then 2 low;
  - de_o bytes 12,34,56,78,... with 8 de_o-high cycles per line and 3-cycle gaps, 2 lines;
  - frame_done pulses once;
  - underflow=0;
  - total frame length 2+2+2*(8+3)+2 = 28 cycles.
- Underflow: pix_valid=0 at the 3rd handshake -> bytes 5-6 of line 0 are 00,00 with de_o=1; underflow=1 until the next vs_o rise.
- Back-to-back frames: enable held 1 -> vs_o rises the cycle after frame_done, period 28 cycles; enable dropped mid-frame -> that frame completes, then IDLE.
- Reset mid-line: assert rst_n=0 during the 3rd byte -> outputs 0 asynchronously; after release, enable=1 -> clean frame from VSYNC.
- Loopback: drive the team's byte-joining receiver with data_out/de_o/vs_o -> receiver reassembles 0x1234, 0x5678 in order. With DVP_TX_COLORBAR_EN and pattern_en=1 -> line pixels FFFF, FFE0, ..., 2 pixels per bar at H_ACTIVE=16.

Source files
------------

// File: rtl/dvp_byte_tx.sv
// DVP camera-side byte transmitter: RGB565 pixels in, high/low bytes out framed by vs_o/de_o timing.
// Build option DVP_TX_COLORBAR_EN adds a pattern_en input selecting an internal 8-bar colour source.
module dvp_byte_tx #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned H_BLANK   = 16,
    parameter int unsigned VS_CYCLES = 8,
    parameter int unsigned V_BACK    = 32,
    parameter int unsigned V_FRONT   = 32
) (
    input  logic        tpclk,
    input  logic        rst_n,
    input  logic        enable,
`ifdef DVP_TX_COLORBAR_EN
    input  logic        pattern_en,
`endif
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  data_out,
    output logic        de_o,
    output logic        vs_o,
    output logic        underflow,
    output logic        frame_done
);

    localparam int unsigned LINE_BYTES = 2 * H_ACTIVE;
    localparam int unsigned BW         = $clog2(LINE_BYTES) + 1;
    localparam int unsigned LW         = $clog2(V_ACTIVE) + 1;
    localparam int unsigned T_A        = (VS_CYCLES > V_BACK) ? VS_CYCLES : V_BACK;
    localparam int unsigned T_B        = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int unsigned T_MAX      = (T_A > T_B) ? T_A : T_B;
    localparam int unsigned TW         = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] VS_LAST   = TW'(VS_CYCLES - 1);
    localparam logic [TW-1:0] VB_LAST   = TW'(V_BACK - 1);
    localparam logic [TW-1:0] HB_LAST   = TW'(H_BLANK - 1);
    localparam logic [TW-1:0] VF_LAST   = TW'(V_FRONT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic [LW-1:0] line_cnt, line_nx;
    logic [7:0]    lo_byte, lo_nx;
    logic [7:0]    data_nx;
    logic          de_nx, vs_nx, und_nx, fd_nx;
    logic          vs_entry;
    logic          load;
    logic          src_ok;
    logic [15:0]   src_pix;

    // Cycle whose next output byte is the high byte of a new pixel.
    always_comb begin
        load = 1'b0;
        case (state)
            VBACK:   load = (tcnt == VB_LAST);
            HBLANK:  load = (tcnt == HB_LAST) && (line_cnt != LINE_LAST);
            ACTIVE:  load = bcnt[0] && (bcnt != BYTE_LAST);
            default: load = 1'b0;
        endcase
    end

`ifdef DVP_TX_COLORBAR_EN
    logic          pat_mode;
    logic [BW-1:0] px;
    logic [2:0]    bar;
    logic [15:0]   bar_pix;

    // Pixel column of the pixel about to be loaded; 0 at the start of every line.
    always_comb begin
        px  = (state == ACTIVE) ? ((bcnt + BW'(1)) >> 1) : '0;
        bar = 3'((32'(px) * 32'd8) / H_ACTIVE);
        case (bar)
            3'd0:    bar_pix = 16'hFFFF;
            3'd1:    bar_pix = 16'hFFE0;
            3'd2:    bar_pix = 16'h07FF;
            3'd3:    bar_pix = 16'h07E0;
            3'd4:    bar_pix = 16'hF81F;
            3'd5:    bar_pix = 16'hF800;
            3'd6:    bar_pix = 16'h001F;
            default: bar_pix = 16'h0000;
        endcase
    end

    // Pattern selection is latched once per frame as VSYNC begins.
    always_ff @(posedge tpclk or negedge rst_n) begin
        if (!rst_n) begin
            pat_mode <= 1'b0;
        end else if (vs_entry) begin
            pat_mode <= pattern_en;
        end
    end

    assign pix_ready = load && !pat_mode;
    assign src_ok    = pat_mode || pix_valid;
    assign src_pix   = pat_mode ? bar_pix : pix_data;
`else
    assign pix_ready = load;
    assign src_ok    = pix_valid;
    assign src_pix   = pix_data;
`endif

    // Next state, counters and next registered outputs.
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bcnt_nx  = bcnt;
        line_nx  = line_cnt;
        lo_nx    = lo_byte;
        data_nx  = 8'h00;
        und_nx   = underflow;
        vs_entry = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = VSYNC;
                    tcnt_nx  = '0;
                end
            end
            VSYNC: begin
                if (tcnt == VS_LAST) begin
                    state_nx = VBACK;
                    tcnt_nx  = '0;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            VBACK: begin
                if (tcnt == VB_LAST) begin
                    state_nx = ACTIVE;
                    tcnt_nx  = '0;
                    bcnt_nx  = '0;
                    line_nx  = '0;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            ACTIVE: begin
                if (bcnt == BYTE_LAST) begin
                    state_nx = HBLANK;
                    tcnt_nx  = '0;
                end else begin
                    bcnt_nx = bcnt + BW'(1);
                end
            end
            HBLANK: begin
                if (tcnt == HB_LAST) begin
                    tcnt_nx = '0;
                    if (line_cnt == LINE_LAST) begin
                        state_nx = VFRONT;
                    end else begin
                        state_nx = ACTIVE;
                        bcnt_nx  = '0;
                        line_nx  = line_cnt + LW'(1);
                    end
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            VFRONT: begin
                if (tcnt == VF_LAST) begin
                    tcnt_nx  = '0;
                    state_nx = enable ? VSYNC : IDLE;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // A missing pixel still occupies its two byte slots, sent as zeros.
        if (load) begin
            data_nx = src_ok ? src_pix[15:8] : 8'h00;
            lo_nx   = src_ok ? src_pix[7:0]  : 8'h00;
            und_nx  = underflow | ~src_ok;
        end else if ((state == ACTIVE) && !bcnt[0]) begin
            data_nx = lo_byte;
        end

        vs_entry = (state_nx == VSYNC) && (state != VSYNC);
        if (vs_entry) begin
            und_nx = 1'b0;
        end

        vs_nx = (state_nx == VSYNC);
        de_nx = (state_nx == ACTIVE);
        fd_nx = (state_nx == VFRONT) && (tcnt_nx == VF_LAST);
    end

    always_ff @(posedge tpclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            bcnt       <= '0;
            line_cnt   <= '0;
            lo_byte    <= 8'h00;
            data_out   <= 8'h00;
            de_o       <= 1'b0;
            vs_o       <= 1'b0;
            underflow  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            tcnt       <= tcnt_nx;
            bcnt       <= bcnt_nx;
            line_cnt   <= line_nx;
            lo_byte    <= lo_nx;
            data_out   <= data_nx;
            de_o       <= de_nx;
            vs_o       <= vs_nx;
            underflow  <= und_nx;
            frame_done <= fd_nx;
        end
    end

endmodule
